// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch compare and redirect, and the EX/MEM register.
// Optional macro EX_MUL_EN adds a 32-cycle shift-add multiplier (alu_ctrl 15) that stalls the front end.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] IDEXpc,
  input  logic [XLEN-1:0] IDEXImm,
  input  logic [XLEN-1:0] IDEXrf_rd0,
  input  logic [XLEN-1:0] IDEXrf_rd1,
  input  logic [4:0]      IDEXRs1,
  input  logic [4:0]      IDEXRs2,
  input  logic [4:0]      IDEXRd,
  input  logic [1:0]      IDEXalu_sel,
  input  logic [3:0]      IDEXalu_ctrl,
  input  logic [2:0]      IDEXcomp_ctrl,
  input  logic [1:0]      IDEXbr_jmp,
  input  logic [7:0]      IDEXwbmem,
  input  logic [4:0]      MEMWBRd,
  input  logic            MEMWBrf_wr_en,
  input  logic [XLEN-1:0] MEMWBwdata,
  output logic [XLEN-1:0] EXMEMalu_out,
  output logic [XLEN-1:0] EXMEMpc4,
  output logic [XLEN-1:0] EXMEMstore_data,
  output logic [4:0]      EXMEMRd,
  output logic [7:0]      EXMEMwbmem,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            ex_stall
);

  logic [XLEN-1:0] fwd_rs1, fwd_rs2, alu_a, alu_b, alu_out, mul_res;
  logic            exm_hit1, exm_hit2, mwb_hit1, mwb_hit2;
  logic            taken, stall_raw;

  // EX/MEM result is newer than MEM/WB, so it wins when both match
  assign exm_hit1 = EXMEMwbmem[7] && (EXMEMRd != 5'd0) && (EXMEMRd == IDEXRs1);
  assign exm_hit2 = EXMEMwbmem[7] && (EXMEMRd != 5'd0) && (EXMEMRd == IDEXRs2);
  assign mwb_hit1 = MEMWBrf_wr_en && (MEMWBRd != 5'd0) && (MEMWBRd == IDEXRs1);
  assign mwb_hit2 = MEMWBrf_wr_en && (MEMWBRd != 5'd0) && (MEMWBRd == IDEXRs2);

  assign fwd_rs1 = exm_hit1 ? EXMEMalu_out : (mwb_hit1 ? MEMWBwdata : IDEXrf_rd0);
  assign fwd_rs2 = exm_hit2 ? EXMEMalu_out : (mwb_hit2 ? MEMWBwdata : IDEXrf_rd1);

  assign alu_a = IDEXalu_sel[1] ? IDEXpc  : fwd_rs1;
  assign alu_b = IDEXalu_sel[0] ? IDEXImm : fwd_rs2;

  always_comb begin
    alu_out = '0;
    case (IDEXalu_ctrl)
      4'd0:  alu_out = alu_a + alu_b;
      4'd1:  alu_out = alu_a - alu_b;
      4'd2:  alu_out = alu_a << alu_b[4:0];
      4'd3:  alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      4'd4:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      4'd5:  alu_out = alu_a ^ alu_b;
      4'd6:  alu_out = alu_a >> alu_b[4:0];
      4'd7:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8:  alu_out = alu_a | alu_b;
      4'd9:  alu_out = alu_a & alu_b;
      4'd10: alu_out = alu_b;
      4'd15: alu_out = mul_res;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (IDEXcomp_ctrl)
      3'd0: taken = (fwd_rs1 == fwd_rs2);
      3'd1: taken = (fwd_rs1 != fwd_rs2);
      3'd4: taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      3'd5: taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'd6: taken = (fwd_rs1 <  fwd_rs2);
      3'd7: taken = (fwd_rs1 >= fwd_rs2);
      default: taken = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;
  mul_state_t      state, state_nx;
  logic [4:0]      cnt;
  logic [XLEN-1:0] mul_a, mul_b, acc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (IDEXalu_ctrl == 4'd15) begin
          mul_a <= alu_a;
          mul_b <= alu_b;
          acc   <= '0;
          cnt   <= 5'd0;
        end
        S_BUSY: begin
          // only the low XLEN bits of the product are kept
          acc <= acc + (mul_b[cnt] ? (mul_a << cnt) : '0);
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    stall_raw = 1'b0;
    case (state)
      S_IDLE: if (IDEXalu_ctrl == 4'd15) begin
        state_nx  = S_BUSY;
        stall_raw = 1'b1;
      end
      S_BUSY: begin
        stall_raw = 1'b1;
        if (cnt == 5'd31) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign mul_res = acc;
`else
  assign stall_raw = 1'b0;
  assign mul_res   = '0;
`endif

  assign ex_stall    = rstn && stall_raw;
  assign pc_redirect = rstn && (taken && IDEXbr_jmp[1] || IDEXbr_jmp[0]) && !ex_stall;
  assign pc_target   = IDEXbr_jmp[0] ? (alu_out & ~{{(XLEN-1){1'b0}}, 1'b1}) : (IDEXpc + IDEXImm);

  // a stalled cycle pushes a bubble so the instruction is not issued twice
  always_ff @(posedge clk) begin
    if (!rstn || ex_stall) begin
      EXMEMalu_out    <= '0;
      EXMEMpc4        <= '0;
      EXMEMstore_data <= '0;
      EXMEMRd         <= 5'd0;
      EXMEMwbmem      <= 8'd0;
    end else begin
      EXMEMalu_out    <= alu_out;
      EXMEMpc4        <= IDEXpc + 32'd4;
      EXMEMstore_data <= fwd_rs2;
      EXMEMRd         <= IDEXRd;
      EXMEMwbmem      <= IDEXwbmem;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; EX/MEM expectations queued at issue, popped one per clock.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] IDEXpc, IDEXImm, IDEXrf_rd0, IDEXrf_rd1, MEMWBwdata;
  logic [4:0]  IDEXRs1, IDEXRs2, IDEXRd, MEMWBRd;
  logic [1:0]  IDEXalu_sel, IDEXbr_jmp;
  logic [3:0]  IDEXalu_ctrl;
  logic [2:0]  IDEXcomp_ctrl;
  logic [7:0]  IDEXwbmem;
  logic        MEMWBrf_wr_en;
  logic [31:0] EXMEMalu_out, EXMEMpc4, EXMEMstore_data, pc_target;
  logic [4:0]  EXMEMRd;
  logic [7:0]  EXMEMwbmem;
  logic        pc_redirect, ex_stall;

  ex_stage dut (
    .clk(clk), .rstn(rstn), .IDEXpc(IDEXpc), .IDEXImm(IDEXImm),
    .IDEXrf_rd0(IDEXrf_rd0), .IDEXrf_rd1(IDEXrf_rd1), .IDEXRs1(IDEXRs1), .IDEXRs2(IDEXRs2),
    .IDEXRd(IDEXRd), .IDEXalu_sel(IDEXalu_sel), .IDEXalu_ctrl(IDEXalu_ctrl),
    .IDEXcomp_ctrl(IDEXcomp_ctrl), .IDEXbr_jmp(IDEXbr_jmp), .IDEXwbmem(IDEXwbmem),
    .MEMWBRd(MEMWBRd), .MEMWBrf_wr_en(MEMWBrf_wr_en), .MEMWBwdata(MEMWBwdata),
    .EXMEMalu_out(EXMEMalu_out), .EXMEMpc4(EXMEMpc4), .EXMEMstore_data(EXMEMstore_data),
    .EXMEMRd(EXMEMRd), .EXMEMwbmem(EXMEMwbmem), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .ex_stall(ex_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, pc4, st;
    logic [4:0]  rd;
    logic [7:0]  wb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, imm, a, b, input logic [4:0] rs1, rs2, rd,
                       input logic [1:0] sel, input logic [3:0] ctrl, input logic [2:0] comp,
                       input logic [1:0] bj, input logic [7:0] wb);
    IDEXpc = pc; IDEXImm = imm; IDEXrf_rd0 = a; IDEXrf_rd1 = b;
    IDEXRs1 = rs1; IDEXRs2 = rs2; IDEXRd = rd; IDEXalu_sel = sel;
    IDEXalu_ctrl = ctrl; IDEXcomp_ctrl = comp; IDEXbr_jmp = bj; IDEXwbmem = wb;
    #1;
  endtask

  task automatic push(input logic [31:0] alu, pc4, st, input logic [4:0] rd, input logic [7:0] wb);
    exp_t e;
    e.alu = alu; e.pc4 = pc4; e.st = st; e.rd = rd; e.wb = wb;
    q.push_back(e);
  endtask

  task automatic push_bubble();
    push(32'd0, 32'd0, 32'd0, 5'd0, 8'd0);
  endtask

  // one clock, then check the oldest expectation against the EX/MEM register
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_alu"}, EXMEMalu_out, e.alu);
      chk({tag, "_pc4"}, EXMEMpc4, e.pc4);
      chk({tag, "_st"},  EXMEMstore_data, e.st);
      chk({tag, "_rd"},  {27'd0, EXMEMRd}, {27'd0, e.rd});
      chk({tag, "_wb"},  {24'd0, EXMEMwbmem}, {24'd0, e.wb});
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    logic [4:0]  rr;
    rstn = 1'b0;
    MEMWBRd = 5'd0; MEMWBrf_wr_en = 1'b0; MEMWBwdata = 32'd0;
    // jump held in EX during reset must not redirect
    drive(32'h40, 32'd0, 32'h203, 32'd0, 5'd0, 5'd0, 5'd1, 2'b01, 4'd0, 3'd0, 2'b01, 8'h80);
    chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    push_bubble(); step("rst");
    rstn = 1'b1;

    // ADD x3 = x1 + x2
    drive(32'h10, 32'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 2'b00, 4'd0, 3'd0, 2'b00, 8'h80);
    chk("add_redirect", {31'd0, pc_redirect}, 32'd0);
    push(32'd12, 32'h14, 32'd7, 5'd3, 8'h80); step("add");

    // set up x4=9 in EX/MEM while MEM/WB also carries x4=1
    drive(32'h20, 32'd9, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4, 2'b01, 4'd0, 3'd0, 2'b00, 8'h80);
    push(32'd9, 32'h24, 32'd0, 5'd4, 8'h80); step("li9");
    MEMWBRd = 5'd4; MEMWBrf_wr_en = 1'b1; MEMWBwdata = 32'd1;
    drive(32'h24, 32'd1, 32'd0, 32'd0, 5'd4, 5'd0, 5'd5, 2'b01, 4'd0, 3'd0, 2'b00, 8'h80);
    push(32'd10, 32'h28, 32'd0, 5'd5, 8'h80); step("fwd_exm");
    // EX/MEM now holds x5, so x4 and rs2 come from MEM/WB
    drive(32'h28, 32'd1, 32'd0, 32'd0, 5'd4, 5'd4, 5'd6, 2'b01, 4'd0, 3'd0, 2'b00, 8'h80);
    push(32'd2, 32'h2C, 32'd1, 5'd6, 8'h80); step("fwd_mwb");
    // x0 producers must never forward
    drive(32'h2C, 32'd77, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'b01, 4'd0, 3'd0, 2'b00, 8'h80);
    push(32'd77, 32'h30, 32'd0, 5'd0, 8'h80); step("wr_x0");
    MEMWBRd = 5'd0; MEMWBwdata = 32'd55;
    drive(32'h30, 32'd1, 32'd3, 32'd0, 5'd0, 5'd0, 5'd7, 2'b01, 4'd0, 3'd0, 2'b00, 8'h80);
    push(32'd4, 32'h34, 32'd0, 5'd7, 8'h80); step("x0_nofwd");
    MEMWBrf_wr_en = 1'b0;

    // BLT -1 < 0 taken, BLTU not taken
    drive(32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 5'd0, 2'b00, 4'd0, 3'd4, 2'b10, 8'h00);
    chk("blt_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("blt_target", pc_target, 32'hF8);
    push(32'hFFFF_FFFF, 32'h104, 32'd0, 5'd0, 8'h00); step("blt");
    drive(32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 5'd1, 5'd2, 5'd0, 2'b00, 4'd0, 3'd6, 2'b10, 8'h00);
    chk("bltu_redirect", {31'd0, pc_redirect}, 32'd0);
    push(32'hFFFF_FFFF, 32'h104, 32'd0, 5'd0, 8'h00); step("bltu");
    // BEQ equal operands taken
    drive(32'h200, 32'h10, 32'd42, 32'd42, 5'd1, 5'd2, 5'd0, 2'b00, 4'd1, 3'd0, 2'b10, 8'h00);
    chk("beq_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("beq_target", pc_target, 32'h210);
    push(32'd0, 32'h204, 32'd42, 5'd0, 8'h00); step("beq");

    // JALR x1, 0(rs1=0x203)
    drive(32'h40, 32'd0, 32'h203, 32'd0, 5'd2, 5'd0, 5'd1, 2'b01, 4'd0, 3'd0, 2'b01, 8'h80);
    chk("jalr_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("jalr_target", pc_target, 32'h202);
    push(32'h203, 32'h44, 32'd0, 5'd1, 8'h80); step("jalr");
    // JAL +0x20 from 0x300
    drive(32'h300, 32'h20, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 2'b11, 4'd0, 3'd0, 2'b01, 8'h80);
    chk("jal_target", pc_target, 32'h320);
    push(32'h320, 32'h304, 32'd0, 5'd1, 8'h80); step("jal");

    // random ALU ops with no hazards (rs=x0 can never match a forward)
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 4'($urandom_range(0, 14));
      rr = 5'($urandom_range(1, 31));
      drive(32'h1000 + 32'(i * 4), 32'd0, ra, rb, 5'd0, 5'd0, rr, 2'b00, rc, 3'd0, 2'b00, 8'h80);
      push(model(rc, ra, rb), 32'h1004 + 32'(i * 4), rb, rr, 8'h80); step("rnd");
    end

`ifdef EX_MUL_EN
    // MUL x6 = x7 * 3 with x7 forwarded from MEM/WB, which then changes mid-operation
    MEMWBRd = 5'd7; MEMWBrf_wr_en = 1'b1; MEMWBwdata = 32'hFFFF_FFFF;
    drive(32'h500, 32'd0, 32'd0, 32'd3, 5'd7, 5'd0, 5'd6, 2'b00, 4'd15, 3'd0, 2'b00, 8'h80);
    chk("mul_stall0", {31'd0, ex_stall}, 32'd1);
    n = 0;
    while (ex_stall && n < 100) begin
      push_bubble(); step("mul_bub");
      n++;
      if (n == 5) begin MEMWBwdata = 32'd5; #1; end
    end
    chk("mul_stall_cycles", 32'(n), 32'd33);
    MEMWBrf_wr_en = 1'b0;
    #1;
    push(32'hFFFF_FFFD, 32'h504, 32'd3, 5'd6, 8'h80); step("mul_done");

    // reset while BUSY with cnt=10
    drive(32'h600, 32'd0, 32'd7, 32'd9, 5'd0, 5'd0, 5'd8, 2'b00, 4'd15, 3'd0, 2'b00, 8'h80);
    for (int i = 0; i < 11; i++) begin push_bubble(); step("mul2_bub"); end
    chk("mul2_busy", {31'd0, ex_stall}, 32'd1);
    rstn = 1'b0; #1;
    chk("mul2_rst_stall", {31'd0, ex_stall}, 32'd0);
    push_bubble(); step("mul2_rst");
    drive(32'h700, 32'd0, 32'd1, 32'd1, 5'd0, 5'd0, 5'd9, 2'b00, 4'd0, 3'd0, 2'b00, 8'h80);
    rstn = 1'b1; #1;
    chk("post_rst_stall", {31'd0, ex_stall}, 32'd0);
    push(32'd2, 32'h704, 32'd1, 5'd9, 8'h80); step("post_rst");
`else
    // without the multiplier, MUL is a single-cycle zero
    drive(32'h500, 32'd0, 32'hFFFF_FFFF, 32'd3, 5'd1, 5'd2, 5'd6, 2'b00, 4'd15, 3'd0, 2'b00, 8'h80);
    chk("mul_nostall", {31'd0, ex_stall}, 32'd0);
    push(32'd0, 32'h504, 32'd3, 5'd6, 8'h80); step("mul_zero");
    n = 0;
    chk("mul_nostall_after", {31'd0, ex_stall}, 32'(n));
`endif

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
